// File: rtl/yuv422_to_rgb.sv
// YUV 4:2:2 byte stream (U,Y0,V,Y1) to 24-bit RGB converter.
// Chroma products are registered once per group, one edge after V is taken.
// Each pixel then passes through a select stage and an output stage, so it
// appears two edges after its Y byte (pixel0 tracks the V byte).
//
// state | meaning
// ------+-------------------------------------------
// S_U   | waiting for U byte (signed chroma blue)
// S_Y0  | waiting for Y0 byte (first luma)
// S_V   | waiting for V byte (signed chroma red)
// S_Y1  | waiting for Y1 byte (second luma)
module yuv422_to_rgb (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_en,
    input  logic [7:0]  yuv_in,
    output logic        busy,
    output logic        out_valid,
    output logic [23:0] rgb_out
);

    typedef enum logic [1:0] {S_U, S_Y0, S_V, S_Y1} state_t;

    state_t             state, state_nxt;
    logic [1:0]         busy_cnt;
    logic               accept, ld_u, ld_y0, ld_v, ld_y1;
    logic [7:0]         u_reg, y0_reg, v_reg, y1_reg;
    logic               p0_go, p1_go;
    logic signed [17:0] cr, cg, cb;
    logic [7:0]         pa_y;
    logic               pa_vld;
    logic signed [19:0] base, r_sum, g_sum, b_sum;

    // Saturate (s >>> 8) to the unsigned 8-bit range.
    function automatic logic [7:0] clamp8(input logic signed [19:0] s);
        logic signed [19:0] q;
        q = s >>> 8;
        if (q < 0)
            clamp8 = 8'h00;
        else if (q > 20'sd255)
            clamp8 = 8'hFF;
        else
            clamp8 = q[7:0];
    endfunction

    // Post-reset hold-off: down-counter, busy until terminal count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            busy_cnt <= 2'd2;
        else if (busy_cnt != 2'd0)
            busy_cnt <= busy_cnt - 2'd1;
    end

    assign busy = (busy_cnt != 2'd0);

    // Byte-position state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= S_U;
        else
            state <= state_nxt;
    end

    // Advance one position per accepted byte; hold across gaps.
    always_comb begin
        state_nxt = state;
        if (accept) begin
            case (state)
                S_U:     state_nxt = S_Y0;
                S_Y0:    state_nxt = S_V;
                S_V:     state_nxt = S_Y1;
                default: state_nxt = S_U;
            endcase
        end
    end

    // Per-state load enables for the byte capture registers.
    always_comb begin
        accept = in_en && !busy;
        ld_u   = 1'b0;
        ld_y0  = 1'b0;
        ld_v   = 1'b0;
        ld_y1  = 1'b0;
        case (state)
            S_U:     ld_u  = accept;
            S_Y0:    ld_y0 = accept;
            S_V:     ld_v  = accept;
            default: ld_y1 = accept;
        endcase
    end

    // Capture bytes and flag which pixel is ready to start.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            u_reg  <= 8'h00;
            y0_reg <= 8'h00;
            v_reg  <= 8'h00;
            y1_reg <= 8'h00;
            p0_go  <= 1'b0;
            p1_go  <= 1'b0;
        end else begin
            if (ld_u)  u_reg  <= yuv_in;
            if (ld_y0) y0_reg <= yuv_in;
            if (ld_v)  v_reg  <= yuv_in;
            if (ld_y1) y1_reg <= yuv_in;
            p0_go <= ld_v;
            p1_go <= ld_y1;
        end
    end

    // Chroma products and luma select. The next group's V arrives at least
    // three edges after Y1, so the chroma terms survive until pixel1 is out.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cr     <= '0;
            cg     <= '0;
            cb     <= '0;
            pa_y   <= 8'h00;
            pa_vld <= 1'b0;
        end else begin
            pa_vld <= p0_go | p1_go;
            if (p0_go) begin
                cr   <= 18'(359 * $signed(v_reg));
                cg   <= 18'(88 * $signed(u_reg) + 183 * $signed(v_reg));
                cb   <= 18'(454 * $signed(u_reg));
                pa_y <= y0_reg;
            end else if (p1_go) begin
                pa_y <= y1_reg;
            end
        end
    end

    // 256*Y + 128 packs directly as {Y, 0x80}.
    always_comb begin
        base  = $signed({4'b0000, pa_y, 8'h80});
        r_sum = base + 20'(cr);
        g_sum = base - 20'(cg);
        b_sum = base + 20'(cb);
    end

    // Output register; rgb_out holds between pixels.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            rgb_out   <= 24'h000000;
        end else begin
            out_valid <= pa_vld;
            if (pa_vld)
                rgb_out <= {clamp8(r_sum), clamp8(g_sum), clamp8(b_sum)};
        end
    end

endmodule

// File: tb/tb_yuv422_to_rgb.sv
// Directed and random-stream bench for yuv422_to_rgb.
module tb_yuv422_to_rgb;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_en = 1'b0;
    logic [7:0]  yuv_in = 8'h00;
    logic        busy;
    logic        out_valid;
    logic [23:0] rgb_out;

    int          n_tests = 0;
    int          n_fail = 0;
    int          cyc = 0;
    bit          mon_en = 1'b0;
    logic [23:0] last_rgb = 24'h0;
    logic [23:0] q_rgb[$];
    int          q_t[$];

    yuv422_to_rgb dut (
        .clk       (clk),
        .reset     (reset),
        .in_en     (in_en),
        .yuv_in    (yuv_in),
        .busy      (busy),
        .out_valid (out_valid),
        .rgb_out   (rgb_out)
    );

    always #5 clk = ~clk;

    // Edge counter used to time pixel pulses.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [7:0] sat(input int v);
        if (v < 0) return 8'h00;
        if (v > 255) return 8'hFF;
        return v[7:0];
    endfunction

    function automatic logic [23:0] model(input logic [7:0] y, input logic [7:0] u, input logic [7:0] v);
        int yi, ui, vi, r, g, b;
        yi = int'(y);
        ui = int'($signed(u));
        vi = int'($signed(v));
        r = (256 * yi + 359 * vi + 128) >>> 8;
        g = (256 * yi - (88 * ui + 183 * vi) + 128) >>> 8;
        b = (256 * yi + 454 * ui + 128) >>> 8;
        return {sat(r), sat(g), sat(b)};
    endfunction

    // Pixel monitor: timing, value, spurious pulses, and hold between pulses.
    always @(negedge clk) begin
        if (mon_en && reset) begin
            if (out_valid) begin
                if (q_rgb.size() == 0) begin
                    chk("extra_pulse", 32'(out_valid), 32'd0);
                end else begin
                    chk("pix_rgb", 32'(rgb_out), 32'(q_rgb[0]));
                    chk("pix_time", 32'(cyc), 32'(q_t[0]));
                    void'(q_rgb.pop_front());
                    void'(q_t.pop_front());
                end
            end else begin
                chk("hold", 32'(rgb_out), 32'(last_rgb));
            end
        end
        last_rgb = rgb_out;
    end

    task automatic put_byte(input logic [7:0] b, output int acc);
        @(negedge clk);
        in_en  = 1'b1;
        yuv_in = b;
        @(posedge clk);
        #1;
        acc = cyc;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_en = 1'b0;
        end
    endtask

    task automatic send_group(input logic [7:0] u, input logic [7:0] y0, input logic [7:0] v,
                              input logic [7:0] y1, input int gap,
                              input logic [23:0] e0, input logic [23:0] e1);
        int t;
        put_byte(u, t);
        put_byte(y0, t);
        put_byte(v, t);
        q_rgb.push_back(e0);
        q_t.push_back(t + 2);
        idle(gap);
        put_byte(y1, t);
        q_rgb.push_back(e1);
        q_t.push_back(t + 2);
    endtask

    initial begin
        int t;
        logic [7:0] u, y0, v, y1;

        // Reset state, asserted without any clock edge.
        #1 reset = 1'b0;
        #2;
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_rgb", 32'(rgb_out), 32'h0);
        repeat (3) @(negedge clk);
        chk("rst_busy_clk", 32'(busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("busy_after_1", 32'(busy), 32'd1);
        @(negedge clk);
        chk("busy_after_2", 32'(busy), 32'd0);
        mon_en = 1'b1;

        // Gray, continuous.
        send_group(8'h00, 8'h80, 8'h00, 8'h10, 0, 24'h808080, 24'h101010);
        // Red.
        send_group(8'hD5, 8'h4C, 8'h7F, 8'h4C, 0, 24'hFE0000, 24'hFE0000);
        // Clamp high / low.
        send_group(8'h7F, 8'hFF, 8'h7F, 8'hFF, 0, 24'hFF79FF, 24'hFF79FF);
        send_group(8'h80, 8'h00, 8'h80, 8'h00, 0, 24'h008800, 24'h008800);
        idle(4);

        // Gap of five idle cycles between V and Y1.
        send_group(8'h00, 8'h80, 8'h00, 8'h10, 5, 24'h808080, 24'h101010);
        idle(6);
        chk("gap_drain", 32'(q_rgb.size()), 32'd0);

        // Reset after U and Y0 accepted.
        put_byte(8'h55, t);
        put_byte(8'h99, t);
        @(negedge clk);
        in_en = 1'b0;
        #2 reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd1);
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        chk("mid_busy_1", 32'(busy), 32'd1);
        chk("mid_valid_1", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("mid_busy_2", 32'(busy), 32'd0);
        chk("mid_valid_2", 32'(out_valid), 32'd0);
        send_group(8'h00, 8'h80, 8'h00, 8'h10, 0, 24'h808080, 24'h101010);
        idle(4);

        // Random back-to-back stream.
        for (int g = 0; g < 500; g++) begin
            u  = 8'($urandom_range(0, 255));
            y0 = 8'($urandom_range(0, 255));
            v  = 8'($urandom_range(0, 255));
            y1 = 8'($urandom_range(0, 255));
            send_group(u, y0, v, y1, 0, model(y0, u, v), model(y1, u, v));
        end
        idle(6);
        chk("stream_drain", 32'(q_rgb.size()), 32'd0);
        chk("end_busy", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/yuv422_to_rgb.md
YUV422_TO_RGB -- requirements
Module: yuv422_to_rgb

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-low reset (0 = reset asserted).
REQ-003 SHALL have port in_en, input, 1 bit: yuv_in carries a valid byte this cycle.
REQ-004 SHALL have port yuv_in, input, 8 bits: byte stream U,Y0,V,Y1 repeating; Y unsigned, U/V two's complement signed.
REQ-005 SHALL have port busy, output, 1 bit: input not accepted this cycle.
REQ-006 SHALL have port out_valid, output, 1 bit: rgb_out valid this cycle (one-cycle pulse per pixel).
REQ-007 SHALL have port rgb_out, output, 24 bits: {R[23:16],G[15:8],B[7:0]}, each unsigned 8 bits.

Function
REQ-008 SHALL accept a byte on a rising edge only when in_en=1 and busy=0; all other cycles leave the input state unchanged.
REQ-009 SHALL track byte position with FSM states S_U -> S_Y0 -> S_V -> S_Y1 -> S_U, advancing one state per accepted byte and holding during in_en=0 gaps of any length.
REQ-010 SHALL register U in S_U, Y0 in S_Y0, V in S_V, Y1 in S_Y1.
REQ-011 SHALL compute, once per group after V acceptance, the registered chroma terms cr=359*V, cg=88*U+183*V, cb=454*U (signed).
REQ-012 SHALL compute each pixel as R=clamp((256*Y+cr+128)>>>8), G=clamp((256*Y-cg+128)>>>8), B=clamp((256*Y+cb+128)>>>8), with >>> arithmetic and intermediates at least 19 bits signed.
REQ-013 SHALL clamp: result <0 -> 0x00, result >255 -> 0xFF, otherwise the low 8 bits.
REQ-014 SHALL output pixel0 (Y0 with the group's U,V) with out_valid=1 exactly 2 cycles after the edge accepting V.
REQ-015 SHALL output pixel1 (Y1 with the same group's U,V) with out_valid=1 exactly 2 cycles after the edge accepting Y1.
REQ-016 SHALL keep a group's chroma terms intact until pixel1 of that group is issued; the next group's U, Y0 and V acceptance does not corrupt the previous group's pending pixel1.
REQ-017 SHALL sustain one byte per cycle with no busy stalls in steady state: continuous input yields pixel0/pixel1 pulses on consecutive cycles, two pixels per 4 bytes.
REQ-018 SHALL hold rgb_out at its last value while out_valid=0.
REQ-019 SHALL assert busy=1 while reset=0 and for exactly 2 cycles after reset deassertion, and busy=0 thereafter.

Reset
REQ-020 SHALL, on reset=0 and independent of clk: set FSM to S_U, out_valid=0, rgb_out=24'h000000, busy=1, and clear all data and chroma registers.
REQ-021 SHALL, on reset mid-group, discard the partial group and all in-flight pixels, issue no out_valid for them, and treat the first accepted byte after the busy window as U.

Verification
REQ-022 SHALL pass gray test: U=00,Y0=80,V=00,Y1=10 continuous -> rgb_out 808080 then 101010 on consecutive out_valid cycles.
REQ-023 SHALL pass red test: U=D5,Y0=4C,V=7F,Y1=4C -> FE0000 twice.
REQ-024 SHALL pass clamp tests: U=7F,Y=FF,V=7F -> FF79FF; U=80,Y=00,V=80 -> 008800.
REQ-025 SHALL pass gap test: gray group with in_en=0 for 5 cycles between V and Y1 -> pixel0 at V+2, pixel1 at Y1+2, no extra out_valid pulses.
REQ-026 SHALL pass mid-group reset test: reset=0 after U,Y0 accepted -> out_valid stays 0, busy=1 for 2 cycles after release, next group U=00,Y0=80,V=00,Y1=10 -> 808080, 101010.
REQ-027 SHALL pass a stream test: 500 random groups back-to-back -> 1000 pixels bit-exact against the REQ-012 model.
